// File: rtl/toy_mem_responder.sv
// toy_mem_responder: byte-wide data memory on the processor bus with
// programmable wait states and a 4-phase MEM_EN/READY handshake.
//
// Ports:
//   CLK, RESET (async, active-high)
//   MEM_EN, WRITE_EN, ADDR[7:0], D_IN[7:0] : request, sampled in IDLE
//   D_OUT[7:0] : registered read data, held across writes and idle
//   READY      : access complete, held until MEM_EN drops
//   ERR        : illegal access flag, valid while READY is high
//   BUSY       : high in the BUSY and DONE states
//
// Optional feature: define TOY_MEM_WRITE_PROTECT_EN to make addresses
// below PROT_LIMIT read-only (writes there are dropped and flag ERR).
module toy_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2,
    parameter int PROT_LIMIT  = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MEM_EN,
    input  logic       WRITE_EN,
    input  logic [7:0] ADDR,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       READY,
    output logic       ERR,
    output logic       BUSY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);
    localparam logic [8:0] PROT9  = 9'(PROT_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] addr_q, addr_n;
    logic [7:0] data_q, data_n;
    logic       we_q, we_n;
    logic [7:0] dout_n;
    logic       ready_n, err_n, busy_n;
    logic       mem_we;
    logic       bad_addr;
    logic       prot_en;
    logic       prot_hit;
    logic [AW-1:0] idx;

    // Contents are deliberately not reset.
    logic [7:0] mem [0:DEPTH-1];

    assign idx      = addr_q[AW-1:0];
    assign bad_addr = ({1'b0, addr_q} >= DEPTH9);

`ifdef TOY_MEM_WRITE_PROTECT_EN
    assign prot_en = 1'b1;
`else
    assign prot_en = 1'b0;
`endif

    // Only writes into the protected window are refused; reads stay legal.
    assign prot_hit = prot_en && we_q && ({1'b0, addr_q} < PROT9);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            we_q   <= 1'b0;
            D_OUT  <= 8'h00;
            READY  <= 1'b0;
            ERR    <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            data_q <= data_n;
            we_q   <= we_n;
            D_OUT  <= dout_n;
            READY  <= ready_n;
            ERR    <= err_n;
            BUSY   <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        data_n  = data_q;
        we_n    = we_q;
        dout_n  = D_OUT;
        ready_n = READY;
        err_n   = ERR;
        busy_n  = BUSY;
        mem_we  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MEM_EN) begin
                    addr_n  = ADDR;
                    data_n  = D_IN;
                    we_n    = WRITE_EN;
                    cnt_n   = 4'(WAIT_STATES);
                    busy_n  = 1'b1;
                    state_n = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // MEM_EN is ignored here: a started access always completes.
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    ready_n = 1'b1;
                    err_n   = bad_addr || prot_hit;
                    state_n = ST_DONE;
                    if (we_q) begin
                        mem_we = !bad_addr && !prot_hit;
                    end else begin
                        dout_n = bad_addr ? 8'h00 : mem[idx];
                    end
                end
            end
            ST_DONE: begin
                if (!MEM_EN) begin
                    ready_n = 1'b0;
                    err_n   = 1'b0;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // mem_we is only raised from BUSY, which reset leaves immediately,
    // so an interrupted write never lands.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_toy_mem_responder.sv
// tb_toy_mem_responder: directed scoreboard bench for toy_mem_responder
// (DEPTH=128, WAIT_STATES=2); a monitor checks each READY completion.
module tb_toy_mem_responder;

    localparam int WS = 2;

    logic       CLK;
    logic       RESET;
    logic       MEM_EN;
    logic       WRITE_EN;
    logic [7:0] ADDR;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic       READY;
    logic       ERR;
    logic       BUSY;

    typedef struct {
        logic [7:0] dout;
        logic       err;
        logic       chk_data;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   n_done;
    logic ready_d;
    logic [7:0] last_dout;

    toy_mem_responder #(
        .DEPTH(128),
        .WAIT_STATES(WS),
        .PROT_LIMIT(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .MEM_EN(MEM_EN),
        .WRITE_EN(WRITE_EN),
        .ADDR(ADDR),
        .D_IN(D_IN),
        .D_OUT(D_OUT),
        .READY(READY),
        .ERR(ERR),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #100 CLK = ~CLK;

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every rising READY pops one expected completion.
    always @(negedge CLK) begin
        if (READY === 1'b1 && ready_d !== 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got READY with empty queue");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_err"}, {7'd0, ERR}, {7'd0, e.err});
                if (e.chk_data) check({e.name, "_dout"}, D_OUT, e.dout);
            end
        end
        ready_d <= READY;
    end

    task automatic access(input string nm, input logic we,
                          input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rd, input logic er,
                          input logic chk, input int hold);
        exp_t e;
        int   n;
        int   done0;
        e.dout     = we ? last_dout : rd;
        e.err      = er;
        e.chk_data = chk;
        e.name     = nm;
        if (!we) last_dout = rd;
        exp_q.push_back(e);
        done0 = n_done;
        @(negedge CLK);
        MEM_EN   = 1'b1;
        WRITE_EN = we;
        ADDR     = a;
        D_IN     = d;
        @(posedge CLK);
        #1;
        // Scramble bus after the sampling edge; DUT must use latched values.
        ADDR     = ~a;
        D_IN     = ~d;
        WRITE_EN = ~we;
        n = 0;
        while (n < 20) begin
            @(posedge CLK);
            n++;
            #1;
            if (READY) break;
        end
        check({nm, "_latency"}, 8'(n), 8'(WS + 1));
        repeat (hold) begin
            @(posedge CLK);
            #1;
            check({nm, "_hold_ready"}, {7'd0, READY}, 8'd1);
        end
        @(negedge CLK);
        MEM_EN = 1'b0;
        @(posedge CLK);
        #1;
        check({nm, "_exit"}, {5'd0, READY, ERR, BUSY}, 8'd0);
        check({nm, "_count"}, 8'(n_done - done0), 8'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        n_done    = 0;
        ready_d   = 1'b0;
        last_dout = 8'h00;
        RESET     = 1'b1;
        MEM_EN    = 1'b0;
        WRITE_EN  = 1'b0;
        ADDR      = 8'h00;
        D_IN      = 8'h00;
        #300;
        check("rst_dout", D_OUT, 8'h00);
        check("rst_flags", {5'd0, READY, ERR, BUSY}, 8'd0);
        #50;
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("idle_dout", D_OUT, 8'h00);
        check("idle_flags", {5'd0, READY, ERR, BUSY}, 8'd0);

        access("wr20", 1'b1, 8'h20, 8'hA5, 8'h00, 1'b0, 1'b1, 0);
        access("rd20", 1'b0, 8'h20, 8'h00, 8'hA5, 1'b0, 1'b1, 0);
        access("wr21", 1'b1, 8'h21, 8'h77, 8'h00, 1'b0, 1'b1, 5);
        access("rd21", 1'b0, 8'h21, 8'h00, 8'h77, 1'b0, 1'b1, 5);

        access("wr10", 1'b1, 8'h10, 8'h66, 8'h00, 1'b0, 1'b1, 0);
        access("rd90", 1'b0, 8'h90, 8'h00, 8'h00, 1'b1, 1'b1, 0);
        access("wr90", 1'b1, 8'h90, 8'h55, 8'h00, 1'b1, 1'b1, 0);
        access("rd10", 1'b0, 8'h10, 8'h00, 8'h66, 1'b0, 1'b1, 0);

        access("wr40", 1'b1, 8'h40, 8'h11, 8'h00, 1'b0, 1'b1, 0);
        @(negedge CLK);
        MEM_EN   = 1'b1;
        WRITE_EN = 1'b1;
        ADDR     = 8'h40;
        D_IN     = 8'h3C;
        @(posedge CLK);
        #1;
        check("pre_rst_busy", {7'd0, BUSY}, 8'd1);
        RESET = 1'b1;
        #5;
        check("mid_rst_dout", D_OUT, 8'h00);
        check("mid_rst_flags", {5'd0, READY, ERR, BUSY}, 8'd0);
        MEM_EN = 1'b0;
        last_dout = 8'h00;
        @(negedge CLK);
        RESET = 1'b0;
        access("rd40", 1'b0, 8'h40, 8'h00, 8'h11, 1'b0, 1'b1, 0);

`ifdef TOY_MEM_WRITE_PROTECT_EN
        access("wr05", 1'b1, 8'h05, 8'hFF, 8'h00, 1'b1, 1'b1, 0);
        access("rd05", 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        access("wr30", 1'b1, 8'h30, 8'hC3, 8'h00, 1'b0, 1'b0, 0);
        access("rd30", 1'b0, 8'h30, 8'h00, 8'hC3, 1'b0, 1'b1, 0);
`else
        access("wr05", 1'b1, 8'h05, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
        access("rd05", 1'b0, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b1, 0);
`endif

        repeat (2) @(posedge CLK);
        check("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
